// File: rtl/trap_ctrl.sv
// trap_ctrl: multi-cycle trap sequencer for the pipelined RV32I core.
// A decode-stage ecall/ebreak/mret stalls the front end and bubbles E while
// older instructions drain. Then (for traps) the machine trap CSRs are
// written, and fetch is redirected to the trap vector or to the saved mepc.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   ValidD                decode holds a real instruction
//   EcallD/EbreakD/MretD  decode system-instruction flags
//   PCD                   PC of the decode instruction
//   MtvecWE/MtvecWD       mtvec CSR write from W
//   StallF/StallD         hold fetch PC / IF-ID register
//   FlushD/FlushE         clear IF-ID / ID-EX register
//   RedirectF/RedirectPC  fetch redirect and its target (0 when not redirecting)
//   Mepc/Mcause/Mtvec     machine trap CSRs
//   Busy                  sequencer not idle
module trap_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ValidD,
  input  logic        EcallD,
  input  logic        EbreakD,
  input  logic        MretD,
  input  logic [31:0] PCD,
  input  logic        MtvecWE,
  input  logic [31:0] MtvecWD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        RedirectF,
  output logic [31:0] RedirectPC,
  output logic [31:0] Mepc,
  output logic [31:0] Mcause,
  output logic [31:0] Mtvec,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, DRAIN, SAVE, REDIRECT} state_t;
  // K_ECALL is the all-zero encoding so the reset value of the pending kind is 0.
  typedef enum logic [1:0] {K_ECALL, K_EBREAK, K_MRET} kind_t;

  typedef struct packed {
    kind_t       kind;
    logic [31:0] pc;
  } pend_t;

  localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  pend_t       pend, pend_nxt;
  logic        trap_req;
  kind_t       req_kind;

  assign trap_req = ValidD & (EcallD | EbreakD | MretD);

  // ecall > ebreak > mret
  always_comb begin
    req_kind = K_MRET;
    if (EcallD)       req_kind = K_ECALL;
    else if (EbreakD) req_kind = K_EBREAK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pend_nxt   = pend;
    StallF     = 1'b0;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    RedirectF  = 1'b0;
    RedirectPC = '0;
    case (state)
      IDLE: begin
        // Same-cycle stall/bubble keeps the trapping instruction out of E.
        if (trap_req) begin
          StallF        = 1'b1;
          StallD        = 1'b1;
          FlushE        = 1'b1;
          pend_nxt.kind = req_kind;
          pend_nxt.pc   = PCD;
          cnt_nxt       = CNT_LOAD;
          state_nxt     = DRAIN;
        end
      end
      DRAIN: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        if (cnt == 4'd0) state_nxt = (pend.kind == K_MRET) ? REDIRECT : SAVE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      SAVE: begin
        StallF    = 1'b1;
        StallD    = 1'b1;
        FlushE    = 1'b1;
        state_nxt = REDIRECT;
      end
      REDIRECT: begin
        RedirectF  = 1'b1;
        FlushD     = 1'b1;
        FlushE     = 1'b1;
        RedirectPC = (pend.kind == K_MRET) ? Mepc : Mtvec;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Trap CSRs: mepc/mcause only move in SAVE; mtvec takes writes in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Mepc   <= '0;
      Mcause <= '0;
      Mtvec  <= RESET_MTVEC;
    end else begin
      if (state == SAVE) begin
        Mepc   <= {pend.pc[31:2], 2'b00};
        Mcause <= (pend.kind == K_EBREAK) ? 32'd3 : 32'd11;
      end
      if (MtvecWE) Mtvec <= {MtvecWD[31:2], 2'b00};
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Multi-cycle trap sequencer for the pipelined RV32I core. It takes the decode-stage system-instruction flags (ecall, ebreak, mret) from the controller and stalls and flushes the front end while older instructions drain. It then updates the machine trap CSRs and redirects fetch to the trap vector or return address. It sits beside the hazard unit; its stall and flush outputs are ORed with the hazard unit's.

## Interface
- DRAIN_CYCLES, 3: cycles spent in DRAIN (older instructions in E/M/W retiring); legal range 1..15.
- RESET_MTVEC, 32'h0000_0100: reset value of Mtvec; bits [1:0] must be 0.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ValidD  in  1  decode stage holds a real instruction, not a bubble.
- EcallD  in  1  decode instruction is ecall.
- EbreakD  in  1  decode instruction is ebreak.
- MretD  in  1  decode instruction is mret.
- PCD  in  32  PC of the decode-stage instruction.
- MtvecWE  in  1  CSR write enable for mtvec (from W stage).
- MtvecWD  in  32  mtvec write data.
- StallF  out  1  hold fetch PC.
- StallD  out  1  hold the IF/ID register.
- FlushD  out  1  clear the IF/ID register.
- FlushE  out  1  clear the ID/EX register (bubble into E).
- RedirectF  out  1  fetch PC := RedirectPC on the next edge.
- RedirectPC  out  32  redirect target.
- Mepc  out  32  saved exception PC.
- Mcause  out  32  trap cause.
- Mtvec  out  32  trap vector base (direct mode only).
- Busy  out  1  FSM not in IDLE.

## Operation
- trap_req = ValidD & (EcallD | EbreakD | MretD). It is sampled only in IDLE; the flags are ignored in all other states.
- Priority when several flags are set at once: ecall > ebreak > mret.
- On trap_req in IDLE:
  - Latch the kind (ECALL/EBREAK/MRET) and PCD into pending registers.
  - Load the drain counter with DRAIN_CYCLES-1.
  - Go to DRAIN.
- States:
  - IDLE: all control outputs 0, except that when trap_req=1, StallF, StallD and FlushE are 1 in that same cycle (combinational). The trapping instruction therefore never enters E.
  - DRAIN: StallF=StallD=FlushE=1. The counter decrements each cycle. When it reaches 0, go to SAVE (trap) or REDIRECT (mret).
  - SAVE: StallF=StallD=FlushE=1. On this edge, Mepc := pending PC with bits [1:0]=0, and Mcause := 32'd11 (ecall) or 32'd3 (ebreak). Go to REDIRECT.
  - REDIRECT: RedirectF=1, FlushD=1, FlushE=1, StallF=StallD=0. Go to IDLE.
- RedirectPC is defined only while RedirectF=1, and is 0 otherwise:
  - trap: the current Mtvec register value.
  - mret: the current Mepc value.
- Mtvec write: on an edge with MtvecWE=1, Mtvec := {MtvecWD[31:2], 2'b00}. Writes are accepted in every state.
- A write landing in DRAIN or SAVE is visible to REDIRECT; a write landing on the REDIRECT edge is not.
- Mepc and Mcause change only in SAVE. mret leaves them unchanged.
- Busy = (state != IDLE).

## Timing
- Reset values (asynchronous, rst_n=0): state IDLE, Mepc=0, Mcause=0, Mtvec=RESET_MTVEC, drain counter 0, pending registers 0. All control outputs are 0 and RedirectPC=0.
- Reset mid-sequence aborts immediately to IDLE. No partial CSR update survives.
- Latency for ecall/ebreak detected in cycle T:
  - DRAIN spans T+1..T+DRAIN_CYCLES.
  - SAVE is cycle T+DRAIN_CYCLES+1.
  - REDIRECT is cycle T+DRAIN_CYCLES+2.
  - Fetch from the vector is at T+DRAIN_CYCLES+3.
- mret latency is one cycle shorter (no SAVE state).
- Back-to-back: a new trap_req is accepted in the cycle after REDIRECT at the earliest. Its flags come from the newly fetched instruction, since D is flushed during REDIRECT.
- Stall and flush outputs are combinational from state plus trap_req and have no registered delay. RedirectPC comes from registers only.

## Test plan
- Ecall, DRAIN_CYCLES=3: ValidD=1, EcallD=1, PCD=32'h0000_0040 at cycle T.
  - Required: FlushE=1 at T; Busy at T+1..T+5.
  - At T+5: RedirectF=1 and RedirectPC=32'h0000_0100.
  - Mepc=32'h40 and Mcause=11 from T+5.
- Ebreak with ecall simultaneously set at PCD=32'h80: Mcause=11, not 3. Repeat with ebreak only: Mcause=3.
- Mret after the first test: MretD=1 at cycle U.
  - Required: RedirectF=1 at U+4 with RedirectPC=32'h40; Mepc and Mcause unchanged.
- Mtvec: MtvecWE=1, MtvecWD=32'h0000_0203 during DRAIN.
  - Required: RedirectPC=32'h0000_0200.
  - Repeat with the write landing in the REDIRECT cycle: RedirectPC is the old vector, and Mtvec=32'h200 afterwards.
- Ignored and gated requests:
  - EcallD=1 with ValidD=0: no state change.
  - EcallD pulsed during DRAIN: no second trap; exactly one REDIRECT.
- Reset: drop rst_n in SAVE. All outputs return to reset values asynchronously, with Mepc=0 and Mtvec=32'h100. After release, a fresh ecall behaves as in the first test.
